waveform_capture_buffer: RTL and testbench
==========================================

# waveform_capture_buffer

Triggered, double-buffered sample store between the ADC timing manager and the VGA generator. It watches the 8-bit ADC sample stream and arms on a rising-edge level crossing. It captures one screen-width of samples into a back buffer and swaps that buffer to the front only during vertical blanking. The VGA generator therefore always draws a complete, tear-free trace, indexed by the horizontal pixel count.

## Interface
Parameters:
- DEPTH, 640: samples per capture, one per visible pixel column.
- ADDR_W, 10: address width; must satisfy 2^ADDR_W >= DEPTH.
- TRIG_LEVEL, 8'd128: trigger threshold, unsigned.
- TIMEOUT, 2048: samples spent in ARM before a forced (auto) trigger; 16-bit counter.
- SWAP_LINE, 480: verticalCount value at which a pending swap is taken.

Ports:
- Clk  in  1  system clock; the only clock.
- scopeRst  in  1  asynchronous, active-high reset.
- sampleValid  in  1  one-cycle strobe, sampleData is new.
- sampleData  in  8  unsigned ADC sample.
- horizontalCount  in  10  current VGA pixel column.
- verticalCount  in  10  current VGA line.
- displayData  out  8  front-buffer sample for the column presented one cycle earlier.
- displayValid  out  1  displayData is a real sample.
- captureBusy  out  1  high while in FILL.
- autoTrig  out  1  latched; the front buffer came from a forced trigger.

## Operation
- Two DEPTH x 8 buffers, A and B. frontSel chooses the buffer being read; the other buffer is written.
- FSM states: ARM, FILL, DONE.
- ARM: on each sampleValid, compare prevSample < TRIG_LEVEL && sampleData >= TRIG_LEVEL. A true compare is a trigger.
  - The triggering sample is written to back[0]; wrPtr <= 1; state goes to FILL.
  - timeoutCnt increments per sampleValid. If the sample arriving when timeoutCnt == TIMEOUT-1 does not trigger, it is force-triggered: same write, and pendAuto <= 1.
- FILL: each sampleValid writes back[wrPtr]. wrPtr increments. When the write to index DEPTH-1 occurs, go to DONE.
- DONE: samples are ignored. On the first cycle with verticalCount == SWAP_LINE && horizontalCount == 0:
  - frontSel toggles, frontLoaded <= 1, autoTrig <= pendAuto.
  - pendAuto, timeoutCnt and wrPtr clear; state goes to ARM.
- prevSample updates on every sampleValid in every state, so a trigger needs a fresh crossing after re-arm.
- Read path: displayData <= front[horizontalCount] when horizontalCount < DEPTH && frontLoaded. Otherwise displayData <= 0 and displayValid <= 0.
- Widths: wrPtr and the read address are ADDR_W bits. timeoutCnt saturates at TIMEOUT-1 and never wraps. All compares are unsigned.

## Timing
- Reset values: state=ARM, frontSel=0, frontLoaded=0, wrPtr=0, timeoutCnt=0, prevSample=8'hFF (the first sample cannot trigger), pendAuto=0, displayData=0, displayValid=0, captureBusy=0, autoTrig=0. Buffer contents are not cleared.
- Read latency: exactly 1 Clk from horizontalCount to displayData/displayValid.
- Write latency: the sample is stored in the cycle after its sampleValid and is never visible on the front side before the swap.
- captureBusy is registered. It rises the cycle after the trigger sample and falls the cycle after the DEPTH-1 write.
- Swap cycle: a read issued in the swap cycle returns the old front buffer. The new buffer is visible from the next cycle.
- sampleValid in the swap cycle is treated as an ARM sample: compared for a trigger against prevSample, counted toward timeout.
- If no swap-condition cycle occurs, DONE holds indefinitely and the front buffer stays displayed.
- Reset asserted mid-FILL or mid-swap: all state returns to reset values immediately. The next frame shows displayValid=0 until a full capture swaps in.

## Test plan
- Reset then ramp 0..255 repeating on sampleValid every 4 Clk, with VGA counters sweeping. Required: the first trigger is on sample 128; after the swap, front[0]=128, front[639]=(128+639) mod 256=255, autoTrig=0.
- Constant sampleData=50 for 3000 samples. Required: forced trigger on the 2048th sample; after the swap, autoTrig=1 and all 640 displayed values are 50.
- Capture completes at verticalCount=100. Required: displayData still comes from the old front until the cycle after verticalCount=480, horizontalCount=0; the new buffer appears from the next read.
- horizontalCount=639 then 640. Required: valid sample then displayValid=0, displayData=0, each one cycle later.
- Assert scopeRst with wrPtr=300 in FILL. Required: all outputs read their reset values at once; after release, displayValid stays 0 until a new full capture swaps in.
- sampleValid coincident with the swap cycle, with prevSample=100, sample=200. Required: that sample triggers, is written to the new back[0], and the swap still occurs.

Source files
------------

// File: rtl/waveform_capture_buffer.sv
// Triggered, double-buffered 8-bit sample store feeding the VGA trace renderer.
// Latency: 1 Clk from horizontalCount to displayData/displayValid; samples land 1 Clk after sampleValid.
// Backpressure: none; samples arriving in DONE are dropped (prevSample still tracks them).
module waveform_capture_buffer #(
  parameter int         DEPTH      = 640,
  parameter int         ADDR_W     = 10,
  parameter logic [7:0] TRIG_LEVEL = 8'd128,
  parameter int         TIMEOUT    = 2048,
  parameter int         SWAP_LINE  = 480
) (
  input  logic       Clk,
  input  logic       scopeRst,
  input  logic       sampleValid,
  input  logic [7:0] sampleData,
  input  logic [9:0] horizontalCount,
  input  logic [9:0] verticalCount,
  output logic [7:0] displayData,
  output logic       displayValid,
  output logic       captureBusy,
  output logic       autoTrig
);

  typedef enum logic [1:0] {ARM, FILL, DONE} stateT;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [15:0]       TO_LAST   = 16'(TIMEOUT - 1);
  localparam logic [10:0]       DEPTH_C   = 11'(DEPTH);
  localparam logic [9:0]        SWAP_L    = 10'(SWAP_LINE);

  stateT             state, nextState;
  logic              frontSel, frontLoaded, pendAuto;
  logic [ADDR_W-1:0] wrPtr;
  logic [15:0]       timeoutCnt;
  logic [7:0]        prevSample;

  logic [7:0]        bufA [DEPTH];
  logic [7:0]        bufB [DEPTH];

  logic              swapNow, armSample, crossing, forced, trig;
  logic              wrEn, wrToB, rdOk;
  logic [ADDR_W-1:0] wrAddr, rdAddr;
  logic [15:0]       armCnt;

  // Next-state decode: swap cycle doubles as an ARM cycle with a freshly cleared timeout count
  always_comb begin
    nextState = state;
    swapNow   = 1'b0;
    armSample = 1'b0;
    forced    = 1'b0;
    trig      = 1'b0;
    wrEn      = 1'b0;
    wrAddr    = '0;
    armCnt    = timeoutCnt;
    crossing  = (prevSample < TRIG_LEVEL) && (sampleData >= TRIG_LEVEL);
    case (state)
      ARM: armSample = sampleValid;
      FILL: begin
        if (sampleValid) begin
          wrEn   = 1'b1;
          wrAddr = wrPtr;
          if (wrPtr == LAST_ADDR) nextState = DONE;
        end
      end
      DONE: begin
        if (verticalCount == SWAP_L && horizontalCount == 10'd0) begin
          swapNow   = 1'b1;
          armCnt    = '0;
          nextState = ARM;
          armSample = sampleValid;
        end
      end
      default: nextState = ARM;
    endcase
    if (armSample) begin
      forced = !crossing && (armCnt == TO_LAST);
      trig   = crossing || forced;
      if (trig) begin
        wrEn      = 1'b1;
        wrAddr    = '0;
        nextState = FILL;
      end
    end
  end

  // Back buffer is the one not selected for display; in the swap cycle it is the outgoing front
  assign wrToB  = swapNow ? frontSel : !frontSel;
  assign rdAddr = ADDR_W'(horizontalCount);
  assign rdOk   = ({1'b0, horizontalCount} < DEPTH_C) && frontLoaded;

  // Control state, pointers, counters and status flags
  always_ff @(posedge Clk or posedge scopeRst) begin
    if (scopeRst) begin
      state       <= ARM;
      frontSel    <= 1'b0;
      frontLoaded <= 1'b0;
      wrPtr       <= '0;
      timeoutCnt  <= '0;
      prevSample  <= 8'hFF;
      pendAuto    <= 1'b0;
      captureBusy <= 1'b0;
      autoTrig    <= 1'b0;
    end else begin
      state       <= nextState;
      captureBusy <= (nextState == FILL);
      if (swapNow) begin
        frontSel    <= !frontSel;
        frontLoaded <= 1'b1;
        autoTrig    <= pendAuto;
        pendAuto    <= 1'b0;
        wrPtr       <= '0;
        timeoutCnt  <= '0;
      end
      if (armSample) begin
        timeoutCnt <= (armCnt == TO_LAST) ? armCnt : armCnt + 16'd1;
        if (trig) wrPtr <= ADDR_W'(1);
        if (forced) pendAuto <= 1'b1;
      end
      if (state == FILL && sampleValid) wrPtr <= wrPtr + ADDR_W'(1);
      if (sampleValid) prevSample <= sampleData;
    end
  end

  // Sample store; contents survive reset
  always_ff @(posedge Clk) begin
    if (wrEn) begin
      if (wrToB) bufB[wrAddr] <= sampleData;
      else       bufA[wrAddr] <= sampleData;
    end
  end

  // Registered front-buffer read; out-of-range columns and an unloaded front read as blank
  always_ff @(posedge Clk or posedge scopeRst) begin
    if (scopeRst) begin
      displayData  <= 8'd0;
      displayValid <= 1'b0;
    end else begin
      displayValid <= rdOk;
      if (rdOk) displayData <= frontSel ? bufB[rdAddr] : bufA[rdAddr];
      else      displayData <= 8'd0;
    end
  end

endmodule

// File: tb/tb_waveform_capture_buffer.sv
// Bench for waveform_capture_buffer: read expectations queued when a column is driven.
// Latency: each queued expectation is compared 1 Clk later, after the next rising edge.
// Backpressure: n/a; stimulus is fixed-length, so the run always terminates.
module tb_waveform_capture_buffer;

  logic       Clk = 1'b0;
  logic       scopeRst;
  logic       sampleValid;
  logic [7:0] sampleData;
  logic [9:0] horizontalCount;
  logic [9:0] verticalCount;
  logic [7:0] displayData;
  logic       displayValid;
  logic       captureBusy;
  logic       autoTrig;

  int nChecks = 0;
  int nErrors = 0;

  typedef struct {
    string      tag;
    logic [8:0] val;
  } expT;
  expT expQ[$];

  waveform_capture_buffer dut (
    .Clk(Clk),
    .scopeRst(scopeRst),
    .sampleValid(sampleValid),
    .sampleData(sampleData),
    .horizontalCount(horizontalCount),
    .verticalCount(verticalCount),
    .displayData(displayData),
    .displayValid(displayValid),
    .captureBusy(captureBusy),
    .autoTrig(autoTrig)
  );

  always #5 Clk = ~Clk;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock, then score every read issued in the cycle just closed
  task automatic step();
    expT e;
    @(posedge Clk);
    #1;
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkEq(e.tag, 32'({displayValid, displayData}), 32'(e.val));
    end
  endtask

  task automatic expectRd(input string tag, input int h, input logic [8:0] val);
    horizontalCount = 10'(h);
    expQ.push_back('{tag: tag, val: val});
  endtask

  task automatic sendSample(input logic [7:0] d);
    sampleValid = 1'b1;
    sampleData  = d;
    step();
    sampleValid = 1'b0;
  endtask

  // Ramp capture: trigger on value 128, so column h holds (128+h) mod 256
  function automatic logic [8:0] rampFront(input int h);
    if (h < 640) return {1'b1, 8'((128 + h) % 256)};
    return 9'd0;
  endfunction

  function automatic logic [7:0] cap3(input int i);
    if (i == 0) return 8'd180;
    return 8'((i * 7) % 256);
  endfunction

  initial begin
    scopeRst        = 1'b1;
    sampleValid     = 1'b0;
    sampleData      = 8'd0;
    horizontalCount = 10'd0;
    verticalCount   = 10'd0;
    repeat (3) step();
    checkEq("rst_data", 32'(displayData), 32'd0);
    checkEq("rst_vld",  32'(displayValid), 32'd0);
    checkEq("rst_busy", 32'(captureBusy), 32'd0);
    checkEq("rst_auto", 32'(autoTrig), 32'd0);
    scopeRst = 1'b0;
    step();

    // Ramp 0..255 every 4 Clk; front still empty while capturing
    for (int s = 0; s < 772; s++) begin
      expectRd("ramp_pre_rd", (s * 3) % 800, 9'd0);
      sendSample(8'(s % 256));
      if (s == 127) checkEq("busy_pre_trig", 32'(captureBusy), 32'd0);
      if (s == 128) checkEq("busy_trig", 32'(captureBusy), 32'd1);
      if (s == 766) checkEq("busy_last", 32'(captureBusy), 32'd1);
      if (s == 767) checkEq("busy_done", 32'(captureBusy), 32'd0);
      repeat (3) step();
    end
    verticalCount = 10'd480;
    expectRd("swap1_old", 0, 9'd0);
    step();
    verticalCount = 10'd0;
    for (int h = 0; h < 800; h++) begin
      expectRd("ramp_rd", h, rampFront(h));
      step();
    end
    checkEq("auto_ramp", 32'(autoTrig), 32'd0);

    // Constant 50: forced trigger on the 2048th sample; completes on line 100
    verticalCount = 10'd100;
    for (int k = 0; k < 3000; k++) begin
      expectRd("old_front_rd", k % 800, rampFront(k % 800));
      sendSample(8'd50);
      if (k == 2046) checkEq("busy_pre_auto", 32'(captureBusy), 32'd0);
      if (k == 2047) checkEq("busy_auto", 32'(captureBusy), 32'd1);
      if (k == 2685) checkEq("busy_auto_last", 32'(captureBusy), 32'd1);
      if (k == 2686) checkEq("busy_auto_done", 32'(captureBusy), 32'd0);
    end
    checkEq("auto_before_swap", 32'(autoTrig), 32'd0);
    verticalCount = 10'd480;
    expectRd("swap2_old", 0, rampFront(0));
    step();
    verticalCount = 10'd0;
    expectRd("swap2_new", 0, {1'b1, 8'd50});
    step();
    for (int h = 0; h < 640; h++) begin
      expectRd("const_rd", h, {1'b1, 8'd50});
      step();
    end
    checkEq("auto_const", 32'(autoTrig), 32'd1);
    expectRd("edge639", 639, {1'b1, 8'd50});
    step();
    expectRd("edge640", 640, 9'd0);
    step();

    // Reset in the middle of a fill with wrPtr at 300
    expectRd("fill5_rd", 10, {1'b1, 8'd50});
    sendSample(8'd150);
    for (int j = 1; j < 300; j++) sendSample(8'(j));
    checkEq("busy_fill5", 32'(captureBusy), 32'd1);
    expectRd("pre_rst_rd", 10, {1'b1, 8'd50});
    step();
    #2;
    scopeRst = 1'b1;
    #1;
    checkEq("mid_rst_data", 32'(displayData), 32'd0);
    checkEq("mid_rst_vld",  32'(displayValid), 32'd0);
    checkEq("mid_rst_busy", 32'(captureBusy), 32'd0);
    checkEq("mid_rst_auto", 32'(autoTrig), 32'd0);
    step();
    step();
    scopeRst = 1'b0;

    // Fresh capture after reset; display stays blank until it swaps in
    expectRd("post_rst_rd", 10, 9'd0);
    sendSample(8'd100);
    expectRd("post_rst_rd", 20, 9'd0);
    sendSample(cap3(0));
    for (int i = 1; i < 640; i++) begin
      expectRd("post_rst_rd", i, 9'd0);
      sendSample(cap3(i));
    end
    checkEq("busy_cap3_done", 32'(captureBusy), 32'd0);
    sendSample(8'd100);

    // Swap cycle carries a 100 -> 200 crossing
    verticalCount = 10'd480;
    expectRd("swap3_old", 0, 9'd0);
    sampleValid = 1'b1;
    sampleData  = 8'd200;
    step();
    sampleValid   = 1'b0;
    verticalCount = 10'd0;
    checkEq("busy_coinc", 32'(captureBusy), 32'd1);
    checkEq("auto_coinc", 32'(autoTrig), 32'd0);
    for (int i = 0; i < 640; i++) begin
      expectRd("cap3_rd", i, {1'b1, cap3(i)});
      sendSample(8'd77);
    end
    checkEq("busy_cap4_done", 32'(captureBusy), 32'd0);
    verticalCount = 10'd480;
    expectRd("swap4_old", 0, {1'b1, 8'd180});
    step();
    verticalCount = 10'd0;
    expectRd("coinc_b0", 0, {1'b1, 8'd200});
    step();
    expectRd("cap4_b1", 1, {1'b1, 8'd77});
    step();
    expectRd("cap4_b639", 639, {1'b1, 8'd77});
    step();
    checkEq("auto_cap4", 32'(autoTrig), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
